sdc_data_receiver: RTL and testbench

//  SD data-block receiver for the read path; counterpart of the SD data transmitter.

---
 rtl/sdc_data_receiver.sv | 161 ++++++++++++++++
 tb/tb_sdc_data_receiver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_data_receiver.sv
// SD read-path data-block receiver: start-bit search, 1/4-bit deserialisation, per-line CRC16 and end-bit check.
// Bytes stream out 1 cycle after their last bit is sampled; there is no backpressure, and done pulses once per finished block.
module sdc_data_receiver #(
  parameter int LEN_W     = 12,
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 wideBus,
  input  logic [LEN_W-1:0]     blockLen,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [3:0]           sdDat,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 crcErr,
  output logic                 frameErr,
  output logic                 timeoutErr
);

  typedef enum logic [2:0] {IDLE, WAIT_START, RX_DATA, RX_CRC, RX_END, DONE} state_t;

  state_t                state;
  logic                  wide;
  logic [LEN_W:0]        total;
  logic [LEN_W:0]        byte_cnt;
  logic [LEN_W:0]        byte_cnt_nxt;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic [TIMEOUT_W-1:0]  wait_cnt_nxt;
  logic [2:0]            bit_cnt;
  logic [3:0]            crc_cnt;
  logic [7:0]            shreg;
  logic [7:0]            byte_next;
  logic [3:0][15:0]      crc;
  logic [3:0][15:0]      rx_crc;
  logic [3:0]            act;
  logic                  byte_end;
  logic                  start_bit;
  logic                  end_bad;
  logic                  crc_bad;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ (((b ^ c[15]) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  assign act          = wide ? 4'hF : 4'h1;
  assign byte_next    = wide ? {shreg[3:0], sdDat} : {shreg[6:0], sdDat[0]};
  assign byte_end     = wide ? bit_cnt[0] : (bit_cnt == 3'd7);
  assign start_bit    = wide ? (sdDat == 4'h0) : ~sdDat[0];
  assign end_bad      = |(act & ~sdDat);
  assign byte_cnt_nxt = byte_cnt + 1'b1;
  assign wait_cnt_nxt = wait_cnt + 1'b1;

  always_comb begin
    crc_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (act[i] && (crc[i] != rx_crc[i])) crc_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wide       <= 1'b0;
      total      <= '0;
      byte_cnt   <= '0;
      wait_cnt   <= '0;
      bit_cnt    <= '0;
      crc_cnt    <= '0;
      shreg      <= '0;
      crc        <= '0;
      rx_crc     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crcErr     <= 1'b0;
      frameErr   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      // abort outranks every event that could complete in the same cycle
      if (abort && (state != IDLE)) begin
        state      <= IDLE;
        busy       <= 1'b0;
        crcErr     <= 1'b0;
        frameErr   <= 1'b0;
        timeoutErr <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              wide       <= wideBus;
              total      <= (blockLen == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, blockLen};
              wait_cnt   <= '0;
              byte_cnt   <= '0;
              bit_cnt    <= '0;
              crc_cnt    <= '0;
              crc        <= '0;
              rx_crc     <= '0;
              crcErr     <= 1'b0;
              frameErr   <= 1'b0;
              timeoutErr <= 1'b0;
              busy       <= 1'b1;
              state      <= WAIT_START;
            end
          end
          WAIT_START: begin
            if (start_bit) begin
              state <= RX_DATA;
            end else begin
              wait_cnt <= wait_cnt_nxt;
              if ((timeout != '0) && (wait_cnt_nxt == timeout)) begin
                timeoutErr <= 1'b1;
                done       <= 1'b1;
                state      <= DONE;
              end
            end
          end
          RX_DATA: begin
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + 1'b1;
            for (int i = 0; i < 4; i++) crc[i] <= crc16_step(crc[i], sdDat[i]);
            if (byte_end) begin
              bit_cnt   <= '0;
              out_data  <= byte_next;
              out_valid <= 1'b1;
              byte_cnt  <= byte_cnt_nxt;
              out_last  <= (byte_cnt_nxt == total);
              if (byte_cnt_nxt == total) state <= RX_CRC;
            end
          end
          RX_CRC: begin
            for (int i = 0; i < 4; i++) rx_crc[i] <= {rx_crc[i][14:0], sdDat[i]};
            crc_cnt <= crc_cnt + 1'b1;
            if (crc_cnt == 4'd15) state <= RX_END;
          end
          RX_END: begin
            frameErr <= end_bad;
            crcErr   <= crc_bad;
            done     <= 1'b1;
            state    <= DONE;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdc_data_receiver.sv
// Directed bench for sdc_data_receiver: scoreboard of expected bytes, checked as the DUT streams them.
module tb_sdc_data_receiver;
  localparam int LEN_W     = 12;
  localparam int TIMEOUT_W = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic                 wideBus;
  logic [LEN_W-1:0]     blockLen;
  logic [TIMEOUT_W-1:0] timeout;
  logic [3:0]           sdDat;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic                 crcErr;
  logic                 frameErr;
  logic                 timeoutErr;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  int exp_gap = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_e;
  logic [15:0] mcrc[4];
  logic        m_wide;

  sdc_data_receiver #(.LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .wideBus(wideBus),
    .blockLen(blockLen), .timeout(timeout), .sdDat(sdDat),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done), .crcErr(crcErr), .frameErr(frameErr), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1) begin
      valid_cnt++;
      chk1("valid_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        chk8("byte", out_data, exp_e[7:0]);
        chk1("last", out_last, exp_e[8]);
      end
      if (exp_gap != 0 && last_valid_cyc >= 0) chkn("byte_gap", cyc - last_valid_cyc, exp_gap);
      last_valid_cyc = cyc;
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    crc_step = {c[14:0], 1'b0};
    if (fb) crc_step = crc_step ^ 16'h1021;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_blk(input logic w, input int len, input logic [3:0] pre_val, input int pre_n);
    wideBus  = w;
    blockLen = len[LEN_W-1:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk1("busy_rise", busy, 1'b1);
    m_wide = w;
    for (int i = 0; i < 4; i++) mcrc[i] = 16'h0000;
    last_valid_cyc = -1;
    repeat (pre_n) begin
      sdDat = pre_val;
      tick();
    end
    sdDat = w ? 4'h0 : 4'hE;
    tick();
  endtask

  task automatic drive_bits(input logic [3:0] v);
    sdDat = v;
    for (int i = 0; i < 4; i++) begin
      if (m_wide || i == 0) mcrc[i] = crc_step(mcrc[i], v[i]);
    end
    tick();
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
    if (m_wide) begin
      drive_bits(b[7:4]);
      drive_bits(b[3:0]);
    end else begin
      for (int k = 7; k >= 0; k--) drive_bits({3'b111, b[k]});
    end
  endtask

  task automatic finish_blk(input logic [3:0] flip, input logic [3:0] end_val,
                            input logic ovr, input logic [15:0] ovr0);
    logic [15:0] c[4];
    logic [3:0]  v;
    for (int i = 0; i < 4; i++) c[i] = mcrc[i];
    if (ovr) c[0] = ovr0;
    for (int k = 15; k >= 0; k--) begin
      v = 4'hF;
      for (int i = 0; i < 4; i++) begin
        if (m_wide || i == 0) v[i] = c[i][k] ^ ((k == 3) ? flip[i] : 1'b0);
      end
      sdDat = v;
      tick();
    end
    sdDat = end_val;
    tick();
    sdDat = 4'hF;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk1({tag, "_done"}, done, 1'b1);
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic f, input logic t);
    chk1({tag, "_crcErr"}, crcErr, c);
    chk1({tag, "_frameErr"}, frameErr, f);
    chk1({tag, "_timeoutErr"}, timeoutErr, t);
  endtask

  initial begin
    int n;
    int base;
    logic [7:0] b8[8];
    rst = 1'b1; start = 1'b0; abort = 1'b0; wideBus = 1'b0;
    blockLen = '0; timeout = '0; sdDat = 4'hF;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk8("rst_data", out_data, 8'h00);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);

    // 1-bit, 512 x 0xFF, reference CRC constant; DAT[3:1] low at the end bit must be ignored
    exp_gap = 8;
    start_blk(1'b0, 512, 4'hF, 3);
    for (int i = 0; i < 512; i++) drive_byte(8'hFF, i == 511);
    finish_blk(4'h0, 4'h1, 1'b1, 16'h7FA1);
    wait_done("t1");
    chk_flags("t1", 1'b0, 1'b0, 1'b0);
    chkn("t1_drained", exp_q.size(), 0);
    tick();
    chk1("t1_busy_drop", busy, 1'b0);

    // wide, 4 bytes, model CRCs
    exp_gap = 2;
    start_blk(1'b1, 4, 4'hF, 2);
    for (int i = 0; i < 4; i++) drive_byte(8'(i + 1), i == 3);
    finish_blk(4'h0, 4'hF, 1'b0, 16'h0);
    wait_done("t2");
    chk_flags("t2", 1'b0, 1'b0, 1'b0);
    tick();

    // same block, one CRC bit flipped on DAT2
    start_blk(1'b1, 4, 4'hF, 1);
    for (int i = 0; i < 4; i++) drive_byte(8'(i + 1), i == 3);
    finish_blk(4'b0100, 4'hF, 1'b0, 16'h0);
    wait_done("t3");
    chk_flags("t3", 1'b1, 1'b0, 1'b0);
    chkn("t3_drained", exp_q.size(), 0);
    tick();

    // start-bit timeout after exactly 100 WAIT_START cycles
    timeout = 100;
    base = valid_cnt;
    wideBus = 1'b1; blockLen = 4; sdDat = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chkn("t4_cycles", n, 100);
    chk_flags("t4", 1'b0, 1'b0, 1'b1);
    tick();
    chkn("t4_no_valid", valid_cnt, base);
    chk1("t4_busy_drop", busy, 1'b0);
    timeout = 0;

    // wide, end bit low on DAT3 only
    start_blk(1'b1, 2, 4'hF, 0);
    drive_byte(8'h5A, 1'b0);
    drive_byte(8'hC3, 1'b1);
    finish_blk(4'h0, 4'b0111, 1'b0, 16'h0);
    wait_done("t5a");
    chk_flags("t5a", 1'b0, 1'b1, 1'b0);
    tick();

    // wide, partial-low 4'hE in WAIT_START is not a start bit
    start_blk(1'b1, 2, 4'hE, 20);
    drive_byte(8'hA5, 1'b0);
    drive_byte(8'h3C, 1'b1);
    finish_blk(4'h0, 4'hF, 1'b0, 16'h0);
    wait_done("t5b");
    chk_flags("t5b", 1'b0, 1'b0, 1'b0);
    tick();

    // abort after 3 of 8 bytes, then a clean block
    for (int i = 0; i < 8; i++) b8[i] = 8'(8'h11 * (i + 1));
    base = done_cnt;
    start_blk(1'b1, 8, 4'hF, 2);
    for (int i = 0; i < 3; i++) drive_byte(b8[i], 1'b0);
    abort = 1'b1;
    sdDat = 4'h0;
    tick();
    abort = 1'b0;
    sdDat = 4'hF;
    chk1("t6_abort_busy", busy, 1'b0);
    chk1("t6_abort_valid", out_valid, 1'b0);
    repeat (10) tick();
    chkn("t6_no_done", done_cnt, base);
    chkn("t6_abort_drained", exp_q.size(), 0);
    start_blk(1'b1, 8, 4'hF, 1);
    for (int i = 0; i < 8; i++) drive_byte(b8[7 - i], i == 7);
    finish_blk(4'h0, 4'hF, 1'b0, 16'h0);
    wait_done("t6b");
    chk_flags("t6b", 1'b0, 1'b0, 1'b0);
    tick();

    // reset in the middle of RX_DATA
    start_blk(1'b0, 8, 4'hF, 0);
    drive_byte(8'h96, 1'b0);
    drive_bits(4'hE);
    drive_bits(4'hF);
    rst = 1'b1;
    tick();
    chk1("t7_busy", busy, 1'b0);
    chk1("t7_valid", out_valid, 1'b0);
    chk1("t7_last", out_last, 1'b0);
    chk1("t7_done", done, 1'b0);
    chk8("t7_data", out_data, 8'h00);
    chk_flags("t7", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    chkn("t7_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
